mem_access_stage: RTL and testbench
===================================

// Module: mem_access_stage
// PURPOSE
//  MEM-stage data-memory access unit between the EX/MEM and MEM/WB pipeline registers.
//  Takes the MEM-stage instruction and drives a req/ack data-memory port.
//  Aligns store data with byte enables, and aligns plus sign/zero-extends load data.
//  Freezes upstream stages with o_stall while an access is outstanding.
//  MEM/WB has no enable, so the unit feeds it a bubble (wreg=0) on every stalled cycle.
// PARAMETERS
//  TIMEOUT  16  max cycles in WAIT before bus error; 0 disables the timeout.
// PORTS
//  i_clk            in   1   clock, rising edge
//  i_resetn         in   1   asynchronous active-low reset
//  i_mem_mem2reg    in   1   MEM instr is a load
//  i_mem_wmem       in   1   MEM instr is a store
//  i_mem_wreg       in   1   MEM instr writes the register file
//  i_mem_rd         in   5   destination register
//  i_mem_alu        in   32  ALU result / effective address
//  i_mem_sdata      in   32  store data (rt), right-justified
//  i_mem_size       in   2   00 byte, 01 half, 10 word, 11 reserved
//  i_mem_unsigned   in   1   1 = zero-extend loads, 0 = sign-extend
//  o_mem_mem2reg    out  1   to MEM/WB
//  o_mem_wreg       out  1   to MEM/WB
//  o_mem_rd         out  5   to MEM/WB
//  o_mem_data       out  32  to MEM/WB: ALU result pass-through
//  o_rd_dmem        out  32  to MEM/WB: aligned, extended load data
//  o_stall          out  1   hold PC, IF/ID, ID/EX and EX/MEM
//  o_misalign       out  1   1-cycle pulse on misaligned or reserved-size access
//  o_bus_err        out  1   1-cycle pulse on timeout
//  o_dmem_req       out  1   memory request
//  o_dmem_we        out  1   1 = write
//  o_dmem_addr      out  32  word address ({alu[31:2],2'b00})
//  o_dmem_be        out  4   byte enables, little-endian
//  o_dmem_wdata     out  32  lane-replicated store data
//  i_dmem_ack       in   1   memory acknowledge (1 cycle)
//  i_dmem_rdata     in   32  read data, valid with ack
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; load capture register 0; timeout counter 0.
//   Reset is asynchronous; mid-access it drops o_dmem_req immediately and abandons the access.
//  Access present = mem2reg|wmem. Misaligned = half & alu[0], word & alu[1:0]!=0, or size=11.
//  IDLE, no access: combinational pass-through of mem2reg/wreg/rd/data, o_rd_dmem=0, o_stall=0.
//  IDLE, misaligned access: no request; o_misalign=1 for one cycle; bubble to WB; no stall.
//   Bubble = wreg=0, mem2reg=0, rd=0, data=0.
//  IDLE, aligned access: o_stall=1; bubble to WB; registers addr/we/be/wdata; next state WAIT.
//  WAIT: o_dmem_req=1; addr/we/be/wdata held stable; o_stall=1; bubble to WB; counter increments.
//   i_dmem_ack=1 -> capture aligned/extended rdata (loads only) -> RESP.
//   Counter reaches TIMEOUT-1 without ack -> o_bus_err=1 for one cycle -> IDLE.
//    In that case the instruction retires as a bubble: o_stall=0 for one cycle, wreg suppressed.
//  RESP (1 cycle): o_dmem_req=0; o_stall=0; outputs present the held instruction.
//   o_rd_dmem = captured load data (0 for stores). Next state IDLE. EX/MEM advances on this edge.
//  Latency: zero-wait memory (ack in first WAIT cycle) gives 2 stall cycles; N wait cycles give N+2.
//  i_dmem_ack outside WAIT is ignored.
//  Byte enables: byte 4'b0001<<alu[1:0]; half alu[1]?1100:0011; word 1111.
//  Store data: byte {4{sdata[7:0]}}, half {2{sdata[15:0]}}, word sdata.
//  Load data: select the lane by alu[1:0], then extend to 32 bits per i_mem_unsigned.
//  No internal buffering: one outstanding access at most.
// TESTING
//  1. Reset: pulse i_resetn low mid-WAIT -> req drops async, all outputs 0, state IDLE.
//  2. ALU op, wreg=1, rd=5, alu=0x1234 -> same cycle o_mem_data=0x1234, o_mem_wreg=1, o_stall=0.
//  3. lb, alu=0x103, rdata=0x80xxxxxx, ack first WAIT cycle:
//     -> addr=0x100, o_stall=1 for 2 cycles, then o_rd_dmem=0xFFFFFF80, o_mem_wreg=1.
//  4. sh, alu=0x202, sdata=0xABCD, ack after 3 waits:
//     -> be=1100, wdata=0xABCDABCD, stall 5 cycles, then wreg=0.
//  5. lw, alu=0x101 -> o_misalign pulse, no req, o_mem_wreg=0, no stall.
//  6. lw, no ack, TIMEOUT=16 -> o_bus_err pulse after 16 WAIT cycles, wreg=0, back to IDLE.

Source files
------------

// File: rtl/mem_access_stage.sv
// MEM-stage data-memory access unit: issues one req/ack access per load/store,
// aligns store lanes and extends load data, and stalls upstream while the access is in flight.
module mem_access_stage #(
   parameter int TIMEOUT = 16
) (
   input  logic        i_clk,
   input  logic        i_resetn,
   input  logic        i_mem_mem2reg,
   input  logic        i_mem_wmem,
   input  logic        i_mem_wreg,
   input  logic [4:0]  i_mem_rd,
   input  logic [31:0] i_mem_alu,
   input  logic [31:0] i_mem_sdata,
   input  logic [1:0]  i_mem_size,
   input  logic        i_mem_unsigned,
   output logic        o_mem_mem2reg,
   output logic        o_mem_wreg,
   output logic [4:0]  o_mem_rd,
   output logic [31:0] o_mem_data,
   output logic [31:0] o_rd_dmem,
   output logic        o_stall,
   output logic        o_misalign,
   output logic        o_bus_err,
   output logic        o_dmem_req,
   output logic        o_dmem_we,
   output logic [31:0] o_dmem_addr,
   output logic [3:0]  o_dmem_be,
   output logic [31:0] o_dmem_wdata,
   input  logic        i_dmem_ack,
   input  logic [31:0] i_dmem_rdata
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;
   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   logic [1:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [31:0]   addr_q, addr_d;
   logic          we_q, we_d;
   logic [3:0]    be_q, be_d;
   logic [31:0]   wdata_q, wdata_d;
   logic [31:0]   rdata_q, rdata_d;

   logic          access, misalign, timeout_hit;
   logic [3:0]    be_calc;
   logic [31:0]   wdata_calc, load_ext;
   logic [7:0]    lane_b;
   logic [15:0]   lane_h;

   assign access = i_mem_mem2reg | i_mem_wmem;

   always_comb begin
      misalign   = 1'b0;
      be_calc    = 4'b1111;
      wdata_calc = i_mem_sdata;
      case (i_mem_size)
         2'b00: begin
            be_calc    = 4'b0001 << i_mem_alu[1:0];
            wdata_calc = {4{i_mem_sdata[7:0]}};
         end
         2'b01: begin
            misalign   = i_mem_alu[0];
            be_calc    = i_mem_alu[1] ? 4'b1100 : 4'b0011;
            wdata_calc = {2{i_mem_sdata[15:0]}};
         end
         2'b10:   misalign = (i_mem_alu[1:0] != 2'b00);
         default: misalign = 1'b1;
      endcase
   end

   // EX/MEM is frozen during the access, so the lane/extension controls are still valid at ack time.
   always_comb begin
      case (i_mem_alu[1:0])
         2'b00:   lane_b = i_dmem_rdata[7:0];
         2'b01:   lane_b = i_dmem_rdata[15:8];
         2'b10:   lane_b = i_dmem_rdata[23:16];
         default: lane_b = i_dmem_rdata[31:24];
      endcase
      lane_h = i_mem_alu[1] ? i_dmem_rdata[31:16] : i_dmem_rdata[15:0];
      case (i_mem_size)
         2'b00:   load_ext = i_mem_unsigned ? {24'b0, lane_b} : {{24{lane_b[7]}}, lane_b};
         2'b01:   load_ext = i_mem_unsigned ? {16'b0, lane_h} : {{16{lane_h[15]}}, lane_h};
         default: load_ext = i_dmem_rdata;
      endcase
   end

   if (TIMEOUT > 0) begin : g_timeout
      assign timeout_hit = (cnt_q == CW'(TIMEOUT - 1));
   end else begin : g_no_timeout
      assign timeout_hit = 1'b0;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      we_d    = we_q;
      be_d    = be_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (access && !misalign) begin
               state_d = S_WAIT;
               addr_d  = {i_mem_alu[31:2], 2'b00};
               we_d    = i_mem_wmem;
               be_d    = be_calc;
               wdata_d = wdata_calc;
               rdata_d = 32'd0;
            end
         end
         S_WAIT: begin
            if (i_dmem_ack) begin
               state_d = S_RESP;
               rdata_d = i_mem_mem2reg ? load_ext : 32'd0;
            end else if (timeout_hit) begin
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_resetn) begin
      if (!i_resetn) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         addr_q  <= 32'd0;
         we_q    <= 1'b0;
         be_q    <= 4'd0;
         wdata_q <= 32'd0;
         rdata_q <= 32'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         we_q    <= we_d;
         be_q    <= be_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
      end
   end

   // Outputs are forced to zero while reset is held so an abandoned access cannot leak through.
   always_comb begin
      o_mem_mem2reg = 1'b0;
      o_mem_wreg    = 1'b0;
      o_mem_rd      = 5'd0;
      o_mem_data    = 32'd0;
      o_rd_dmem     = 32'd0;
      o_stall       = 1'b0;
      o_misalign    = 1'b0;
      o_bus_err     = 1'b0;
      o_dmem_req    = 1'b0;
      o_dmem_we     = 1'b0;
      o_dmem_addr   = 32'd0;
      o_dmem_be     = 4'd0;
      o_dmem_wdata  = 32'd0;
      if (i_resetn) begin
         o_dmem_we    = we_q;
         o_dmem_addr  = addr_q;
         o_dmem_be    = be_q;
         o_dmem_wdata = wdata_q;
         case (state_q)
            S_IDLE: begin
               if (!access) begin
                  o_mem_mem2reg = i_mem_mem2reg;
                  o_mem_wreg    = i_mem_wreg;
                  o_mem_rd      = i_mem_rd;
                  o_mem_data    = i_mem_alu;
               end else if (misalign) begin
                  o_misalign = 1'b1;
               end else begin
                  o_stall = 1'b1;
               end
            end
            S_WAIT: begin
               o_dmem_req = 1'b1;
               o_bus_err  = timeout_hit && !i_dmem_ack;
               o_stall    = !(timeout_hit && !i_dmem_ack);
            end
            S_RESP: begin
               o_mem_mem2reg = i_mem_mem2reg;
               o_mem_wreg    = i_mem_wreg;
               o_mem_rd      = i_mem_rd;
               o_mem_data    = i_mem_alu;
               o_rd_dmem     = rdata_q;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: each task drives one scenario and checks hand-computed results.
module tb_mem_access_stage;

   logic        i_clk, i_resetn;
   logic        i_mem_mem2reg, i_mem_wmem, i_mem_wreg, i_mem_unsigned;
   logic [4:0]  i_mem_rd;
   logic [31:0] i_mem_alu, i_mem_sdata;
   logic [1:0]  i_mem_size;
   logic        o_mem_mem2reg, o_mem_wreg, o_stall, o_misalign, o_bus_err;
   logic [4:0]  o_mem_rd;
   logic [31:0] o_mem_data, o_rd_dmem;
   logic        o_dmem_req, o_dmem_we, i_dmem_ack;
   logic [31:0] o_dmem_addr, o_dmem_wdata, i_dmem_rdata;
   logic [3:0]  o_dmem_be;

   int errors = 0;
   int checks = 0;

   // results captured by run_access
   int          n_stall, n_req;
   logic        got_resp, bubble_bad;
   logic [31:0] cap_addr, cap_wdata;
   logic [3:0]  cap_be;
   logic        cap_we;
   logic        r_wreg, r_m2r, r_misalign, r_bus_err;
   logic [4:0]  r_rd;
   logic [31:0] r_data, r_rd_dmem;

   mem_access_stage #(.TIMEOUT(16)) dut (
      .i_clk(i_clk), .i_resetn(i_resetn),
      .i_mem_mem2reg(i_mem_mem2reg), .i_mem_wmem(i_mem_wmem), .i_mem_wreg(i_mem_wreg),
      .i_mem_rd(i_mem_rd), .i_mem_alu(i_mem_alu), .i_mem_sdata(i_mem_sdata),
      .i_mem_size(i_mem_size), .i_mem_unsigned(i_mem_unsigned),
      .o_mem_mem2reg(o_mem_mem2reg), .o_mem_wreg(o_mem_wreg), .o_mem_rd(o_mem_rd),
      .o_mem_data(o_mem_data), .o_rd_dmem(o_rd_dmem), .o_stall(o_stall),
      .o_misalign(o_misalign), .o_bus_err(o_bus_err),
      .o_dmem_req(o_dmem_req), .o_dmem_we(o_dmem_we), .o_dmem_addr(o_dmem_addr),
      .o_dmem_be(o_dmem_be), .o_dmem_wdata(o_dmem_wdata),
      .i_dmem_ack(i_dmem_ack), .i_dmem_rdata(i_dmem_rdata)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   task automatic clear_inputs();
      i_mem_mem2reg = 0; i_mem_wmem = 0; i_mem_wreg = 0; i_mem_rd = 0;
      i_mem_alu = 0; i_mem_sdata = 0; i_mem_size = 0; i_mem_unsigned = 0;
      i_dmem_ack = 0; i_dmem_rdata = 0;
   endtask

   task automatic idle_inputs();
      @(posedge i_clk); #1;
      clear_inputs();
      #1;
   endtask

   // Drives one instruction at posedge+1 and follows it until o_stall drops (bounded).
   // ack_at = index of the WAIT cycle (1-based) that receives the ack; 0 = never.
   task automatic run_access(input logic m2r, input logic wm, input logic wr, input logic [4:0] rd,
                             input logic [31:0] alu, input logic [31:0] sd, input logic [1:0] sz,
                             input logic uns, input int ack_at, input logic [31:0] rdata);
      @(posedge i_clk); #1;
      i_mem_mem2reg = m2r; i_mem_wmem = wm; i_mem_wreg = wr; i_mem_rd = rd;
      i_mem_alu = alu; i_mem_sdata = sd; i_mem_size = sz; i_mem_unsigned = uns;
      i_dmem_rdata = rdata; i_dmem_ack = 0;
      n_stall = 0; n_req = 0; got_resp = 0; bubble_bad = 0;
      cap_addr = 0; cap_wdata = 0; cap_be = 0; cap_we = 0;
      for (int n = 0; n < 40; n++) begin
         #1;
         if (o_dmem_req) begin
            n_req++;
            if (n_req == 1) begin
               cap_addr = o_dmem_addr; cap_wdata = o_dmem_wdata;
               cap_be = o_dmem_be; cap_we = o_dmem_we;
            end
         end
         if (!o_stall) begin
            got_resp = 1;
            r_wreg = o_mem_wreg; r_m2r = o_mem_mem2reg; r_rd = o_mem_rd; r_data = o_mem_data;
            r_rd_dmem = o_rd_dmem; r_misalign = o_misalign; r_bus_err = o_bus_err;
            break;
         end
         n_stall++;
         if (o_mem_wreg || o_mem_mem2reg || o_mem_rd != 0 || o_mem_data != 0) bubble_bad = 1;
         if (o_dmem_req && n_req == ack_at) i_dmem_ack = 1;
         @(posedge i_clk); #1;
         i_dmem_ack = 0;
      end
      $display("access alu=%h m2r=%0d wm=%0d size=%0d: stalls=%0d reqs=%0d rd_dmem=%h wreg=%0d",
               alu, m2r, wm, sz, n_stall, n_req, r_rd_dmem, r_wreg);
   endtask

   task automatic test_reset();
      clear_inputs();
      i_resetn = 0;
      #3;
      checks++; if (o_stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", o_stall); end
      checks++; if (o_dmem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b want 0", o_dmem_req); end
      checks++; if (o_dmem_addr !== 32'd0) begin errors++; $display("FAIL reset_addr got %h want 0", o_dmem_addr); end
      @(posedge i_clk); #2;
      i_resetn = 1;
      $display("reset released");
   endtask

   task automatic test_alu_pass();
      @(posedge i_clk); #1;
      i_mem_wreg = 1; i_mem_rd = 5'd5; i_mem_alu = 32'h1234;
      i_dmem_ack = 1;
      #1;
      checks++; if (o_mem_data !== 32'h1234) begin errors++; $display("FAIL alu_data got %h want 00001234", o_mem_data); end
      checks++; if (o_mem_wreg !== 1'b1) begin errors++; $display("FAIL alu_wreg got %b want 1", o_mem_wreg); end
      checks++; if (o_mem_rd !== 5'd5) begin errors++; $display("FAIL alu_rd got %0d want 5", o_mem_rd); end
      checks++; if (o_stall !== 1'b0) begin errors++; $display("FAIL alu_stall got %b want 0", o_stall); end
      @(posedge i_clk); #2;
      checks++; if (o_dmem_req !== 1'b0) begin errors++; $display("FAIL stray_ack_req got %b want 0", o_dmem_req); end
      $display("alu pass-through alu=%h wreg=%0d rd=%0d", o_mem_data, o_mem_wreg, o_mem_rd);
      idle_inputs();
   endtask

   task automatic test_load_byte();
      run_access(1, 0, 1, 5'd7, 32'h103, 32'h0, 2'b00, 0, 1, 32'h80123456);
      checks++; if (cap_addr !== 32'h100) begin errors++; $display("FAIL lb_addr got %h want 00000100", cap_addr); end
      checks++; if (cap_be !== 4'b1000) begin errors++; $display("FAIL lb_be got %b want 1000", cap_be); end
      checks++; if (n_stall !== 2) begin errors++; $display("FAIL lb_stalls got %0d want 2", n_stall); end
      checks++; if (r_rd_dmem !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_data got %h want ffffff80", r_rd_dmem); end
      checks++; if (r_wreg !== 1'b1 || r_rd !== 5'd7) begin errors++; $display("FAIL lb_wb got wreg=%b rd=%0d want 1/7", r_wreg, r_rd); end
      checks++; if (bubble_bad !== 1'b0) begin errors++; $display("FAIL lb_bubble got %b want 0", bubble_bad); end
      run_access(1, 0, 1, 5'd8, 32'h102, 32'h0, 2'b00, 1, 1, 32'h00C30000);
      checks++; if (r_rd_dmem !== 32'h000000C3) begin errors++; $display("FAIL lbu_data got %h want 000000c3", r_rd_dmem); end
      idle_inputs();
   endtask

   task automatic test_half_loads();
      run_access(1, 0, 1, 5'd9, 32'h102, 32'h0, 2'b01, 1, 1, 32'h80011234);
      checks++; if (r_rd_dmem !== 32'h00008001) begin errors++; $display("FAIL lhu_data got %h want 00008001", r_rd_dmem); end
      checks++; if (cap_be !== 4'b1100) begin errors++; $display("FAIL lhu_be got %b want 1100", cap_be); end
      run_access(1, 0, 1, 5'd10, 32'h100, 32'h0, 2'b01, 0, 2, 32'h1234FF00);
      checks++; if (r_rd_dmem !== 32'hFFFFFF00) begin errors++; $display("FAIL lh_data got %h want ffffff00", r_rd_dmem); end
      checks++; if (n_stall !== 3) begin errors++; $display("FAIL lh_stalls got %0d want 3", n_stall); end
      idle_inputs();
   endtask

   task automatic test_store_half();
      run_access(0, 1, 0, 5'd0, 32'h202, 32'h0000ABCD, 2'b01, 0, 4, 32'h0);
      checks++; if (cap_be !== 4'b1100) begin errors++; $display("FAIL sh_be got %b want 1100", cap_be); end
      checks++; if (cap_wdata !== 32'hABCDABCD) begin errors++; $display("FAIL sh_wdata got %h want abcdabcd", cap_wdata); end
      checks++; if (cap_we !== 1'b1 || cap_addr !== 32'h200) begin errors++; $display("FAIL sh_we_addr got %b/%h want 1/00000200", cap_we, cap_addr); end
      checks++; if (n_stall !== 5) begin errors++; $display("FAIL sh_stalls got %0d want 5", n_stall); end
      checks++; if (r_wreg !== 1'b0 || r_rd_dmem !== 32'd0) begin errors++; $display("FAIL sh_wb got wreg=%b rd_dmem=%h want 0/0", r_wreg, r_rd_dmem); end
      idle_inputs();
   endtask

   task automatic test_back_to_back();
      run_access(1, 0, 1, 5'd3, 32'h104, 32'h0, 2'b10, 0, 1, 32'hDEADBEEF);
      checks++; if (r_rd_dmem !== 32'hDEADBEEF || cap_be !== 4'b1111) begin errors++; $display("FAIL b2b_lw got %h be=%b want deadbeef/1111", r_rd_dmem, cap_be); end
      run_access(0, 1, 0, 5'd0, 32'h001, 32'h123456A5, 2'b00, 0, 1, 32'h0);
      checks++; if (cap_be !== 4'b0010 || cap_wdata !== 32'hA5A5A5A5) begin errors++; $display("FAIL b2b_sb got be=%b wdata=%h want 0010/a5a5a5a5", cap_be, cap_wdata); end
      checks++; if (cap_addr !== 32'h0 || n_stall !== 2) begin errors++; $display("FAIL b2b_sb_addr got %h stalls=%0d want 0/2", cap_addr, n_stall); end
      idle_inputs();
   endtask

   task automatic test_misalign();
      run_access(1, 0, 1, 5'd4, 32'h101, 32'h0, 2'b10, 0, 0, 32'h0);
      checks++; if (r_misalign !== 1'b1) begin errors++; $display("FAIL lw_misalign got %b want 1", r_misalign); end
      checks++; if (n_req !== 0 || n_stall !== 0) begin errors++; $display("FAIL lw_mis_nostall got req=%0d stall=%0d want 0/0", n_req, n_stall); end
      checks++; if (r_wreg !== 1'b0 || r_rd !== 5'd0 || r_data !== 32'd0) begin errors++; $display("FAIL lw_mis_bubble got wreg=%b rd=%0d data=%h want 0", r_wreg, r_rd, r_data); end
      idle_inputs();
      checks++; if (o_misalign !== 1'b0) begin errors++; $display("FAIL mis_pulse_end got %b want 0", o_misalign); end
      run_access(1, 0, 1, 5'd4, 32'h100, 32'h0, 2'b11, 0, 0, 32'h0);
      checks++; if (r_misalign !== 1'b1 || n_req !== 0) begin errors++; $display("FAIL rsv_size got mis=%b req=%0d want 1/0", r_misalign, n_req); end
      run_access(0, 1, 0, 5'd0, 32'h203, 32'h0, 2'b01, 0, 0, 32'h0);
      checks++; if (r_misalign !== 1'b1 || n_req !== 0) begin errors++; $display("FAIL sh_mis got mis=%b req=%0d want 1/0", r_misalign, n_req); end
      idle_inputs();
   endtask

   task automatic test_timeout();
      run_access(1, 0, 1, 5'd6, 32'h400, 32'h0, 2'b10, 0, 0, 32'h0);
      checks++; if (got_resp !== 1'b1) begin errors++; $display("FAIL to_end got %b want 1", got_resp); end
      checks++; if (r_bus_err !== 1'b1) begin errors++; $display("FAIL to_bus_err got %b want 1", r_bus_err); end
      checks++; if (n_req !== 16 || n_stall !== 16) begin errors++; $display("FAIL to_cycles got req=%0d stall=%0d want 16/16", n_req, n_stall); end
      checks++; if (r_wreg !== 1'b0) begin errors++; $display("FAIL to_wreg got %b want 0", r_wreg); end
      idle_inputs();
      checks++; if (o_bus_err !== 1'b0 || o_dmem_req !== 1'b0 || o_stall !== 1'b0) begin errors++; $display("FAIL to_idle got err=%b req=%b stall=%b want 0", o_bus_err, o_dmem_req, o_stall); end
   endtask

   task automatic test_async_reset();
      @(posedge i_clk); #1;
      i_mem_mem2reg = 1; i_mem_wreg = 1; i_mem_rd = 5'd2; i_mem_alu = 32'h300; i_mem_size = 2'b10;
      @(posedge i_clk); #1;
      checks++; if (o_dmem_req !== 1'b1) begin errors++; $display("FAIL ar_wait_req got %b want 1", o_dmem_req); end
      #2 i_resetn = 0;
      #1;
      checks++; if (o_dmem_req !== 1'b0 || o_stall !== 1'b0) begin errors++; $display("FAIL ar_drop got req=%b stall=%b want 0/0", o_dmem_req, o_stall); end
      checks++; if (o_dmem_addr !== 32'd0 || o_dmem_be !== 4'd0 || o_mem_wreg !== 1'b0) begin errors++; $display("FAIL ar_zero got addr=%h be=%b wreg=%b want 0", o_dmem_addr, o_dmem_be, o_mem_wreg); end
      @(posedge i_clk); #1;
      clear_inputs();
      i_resetn = 1;
      @(posedge i_clk); #1;
      checks++; if (o_dmem_req !== 1'b0 || o_stall !== 1'b0) begin errors++; $display("FAIL ar_idle got req=%b stall=%b want 0/0", o_dmem_req, o_stall); end
      $display("async reset mid-WAIT done");
   endtask

   initial begin
      test_reset();
      test_alu_pass();
      test_load_byte();
      test_half_loads();
      test_store_half();
      test_back_to_back();
      test_misalign();
      test_timeout();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
